// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: hazard and forwarding controller for the in-order pipeline.
// A DEPTH-entry shift-register scoreboard mirrors the stages after Decode
// (entry 0 = E, entry DEPTH-1 = W). Each entry records whether the instruction
// writes a register, which register, and the stage index at which its result
// becomes forwardable. Stall/flush are combinational; forward selects are
// registered as the D instruction moves into E.
// Optional feature: define HAZARD_PERF_EN to build the stall/redirect counters;
// otherwise both counter ports are tied to zero.
module hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 3,
    parameter int ALU_RDY  = 1,
    parameter int LOAD_RDY = 2,
    parameter int FW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_valid_i,
    input  logic [REG_AW-1:0] rs1_d_i,
    input  logic [REG_AW-1:0] rs2_d_i,
    input  logic [REG_AW-1:0] rd_d_i,
    input  logic              regwrite_d_i,
    input  logic              load_d_i,
    input  logic              redirect_e_i,
    input  logic              hold_i,
    output logic              stall_f_o,
    output logic              stall_d_o,
    output logic              flush_d_o,
    output logic              flush_e_o,
    output logic [FW-1:0]     fwd_a_e_o,
    output logic [FW-1:0]     fwd_b_e_o,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
);

    localparam logic [FW-1:0] ALU_RDY_V  = FW'(ALU_RDY);
    localparam logic [FW-1:0] LOAD_RDY_V = FW'(LOAD_RDY);

    // Scoreboard contents, one entry per tracked stage.
    logic [DEPTH-1:0]  valid_reg;
    logic [REG_AW-1:0] rd_reg  [DEPTH];
    logic [FW-1:0]     rdy_reg [DEPTH];

    // Per-entry match and "result not yet forwardable" flags for both sources.
    logic [DEPTH-1:0]  hit1;
    logic [DEPTH-1:0]  hit2;
    logic [DEPTH-1:0]  early;

    logic              haz1;
    logic              haz2;
    logic [FW-1:0]     sel1;
    logic [FW-1:0]     sel2;
    logic              stall;
    logic              advance;

    // Forward select for a producer sitting in entry i when the consumer
    // reaches E: it will then be one stage further on. The last stage is
    // covered by register-file write-through, so it selects the register file.
    function automatic logic [FW-1:0] stage_sel(input int i);
        if (i + 1 <= DEPTH - 1) begin
            return FW'(i + 1);
        end
        return '0;
    endfunction

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign hit1[gi]  = valid_reg[gi] && (rd_reg[gi] == rs1_d_i) && (rs1_d_i != '0);
            assign hit2[gi]  = valid_reg[gi] && (rd_reg[gi] == rs2_d_i) && (rs2_d_i != '0);
            // Producer one stage ahead of its ready point still cannot forward.
            assign early[gi] = (FW'(gi + 1) < rdy_reg[gi]);
        end
    endgenerate

    // Youngest matching writer (lowest index) decides hazard and forward select.
    always_comb begin
        haz1 = 1'b0;
        haz2 = 1'b0;
        sel1 = '0;
        sel2 = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hit1[i]) begin
                haz1 = early[i];
                sel1 = stage_sel(i);
            end
            if (hit2[i]) begin
                haz2 = early[i];
                sel2 = stage_sel(i);
            end
        end
    end

    assign stall   = d_valid_i && (haz1 || haz2);
    assign advance = d_valid_i && !stall && !redirect_e_i;

    // Pipeline control outputs with hold > redirect > stall priority.
    always_comb begin
        stall_f_o = 1'b0;
        stall_d_o = 1'b0;
        flush_d_o = 1'b0;
        flush_e_o = 1'b0;
        if (hold_i) begin
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
        end else if (redirect_e_i) begin
            flush_d_o = 1'b1;
            flush_e_o = 1'b1;
        end else if (stall) begin
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
            flush_e_o = 1'b1;
        end
    end

    // Scoreboard shift: entry 0 takes the advancing D instruction or a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_reg[i]  <= '0;
                rdy_reg[i] <= '0;
            end
        end else if (!hold_i) begin
            valid_reg[0] <= advance && regwrite_d_i && (rd_d_i != '0);
            rd_reg[0]    <= rd_d_i;
            rdy_reg[0]   <= load_d_i ? LOAD_RDY_V : ALU_RDY_V;
            for (int i = 1; i < DEPTH; i++) begin
                valid_reg[i] <= valid_reg[i-1];
                rd_reg[i]    <= rd_reg[i-1];
                rdy_reg[i]   <= rdy_reg[i-1];
            end
        end
    end

    // Forward selects follow the instruction into E; bubbles select the register file.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_a_e_o <= '0;
            fwd_b_e_o <= '0;
        end else if (!hold_i) begin
            fwd_a_e_o <= advance ? sel1 : '0;
            fwd_b_e_o <= advance ? sel2 : '0;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] flush_cnt_reg;

    // Saturating counts of recorded stall cycles and accepted redirects.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else if (!hold_i) begin
            if (stall && !redirect_e_i && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
            if (redirect_e_i && (flush_cnt_reg != 32'hFFFF_FFFF)) begin
                flush_cnt_reg <= flush_cnt_reg + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
    assign flush_cnt_o = flush_cnt_reg;
`else
    assign stall_cnt_o = 32'd0;
    assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding controller for the in-order pipeline. It replaces fixed-stage hazard detection with an internal shift-register scoreboard that mirrors the DEPTH pipeline stages after Decode. Each tracked instruction carries its destination and the stage index at which its result becomes forwardable. The block sits between Decode and Execute, drives Fetch/Decode stall and flush, and supplies registered forward selects for the Execute operand muxes.

## Interface
Parameters:
- REG_AW, 5, register address width.
- DEPTH, 3, number of tracked stages after D; index 0 = E, DEPTH-1 = W; legal range 2..6.
- ALU_RDY, 1, stage index at which ALU or jump results become forwardable; 1..DEPTH-1.
- LOAD_RDY, 2, stage index at which load results become forwardable; ALU_RDY..DEPTH-1.
- FW, $clog2(DEPTH+1), forward-select width.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-low reset.
- d_valid_i, input, 1, valid instruction in D.
- rs1_d_i, input, REG_AW, source register 1 of the D instruction.
- rs2_d_i, input, REG_AW, source register 2 of the D instruction.
- rd_d_i, input, REG_AW, destination register of the D instruction.
- regwrite_d_i, input, 1, D instruction writes rd.
- load_d_i, input, 1, D instruction is a load.
- redirect_e_i, input, 1, taken branch or jump resolved in E (PCSrcE).
- hold_i, input, 1, global freeze (memory wait).
- stall_f_o, output, 1, hold PC.
- stall_d_o, output, 1, hold F/D register.
- flush_d_o, output, 1, clear F/D register.
- flush_e_o, output, 1, clear D/E register.
- fwd_a_e_o, output, FW, operand A select for the instruction in E: 0 = register file, k = tracked stage k.
- fwd_b_e_o, output, FW, operand B select, same encoding as fwd_a_e_o.
- stall_cnt_o, output, 32, stall-cycle count.
- flush_cnt_o, output, 32, redirect count.

## Operation
- Scoreboard: DEPTH entries, each holding {valid, rd, rdy}. On each non-hold cycle, entry i moves to i+1 and entry DEPTH-1 retires.
- Entry 0 load:
  - Loaded from D when d_valid_i & !stall & !redirect_e_i.
  - Entry valid = regwrite_d_i & (rd_d_i != 0).
  - Entry rdy = load_d_i ? LOAD_RDY : ALU_RDY.
  - Otherwise entry 0 loads a bubble (valid = 0).
- Source match, for each source rs used by the D instruction:
  - rs = x0 never matches.
  - Otherwise find the lowest index i with valid & rd == rs; the youngest writer wins.
- Hazard for a matching source: i+1 < rdy_i. stall = d_valid_i & (hazard on rs1 | hazard on rs2).
- Forward select:
  - Next forward select = i+1 when a match exists and i+1 <= DEPTH-1.
  - Otherwise the select is 0. This covers a match at DEPTH-1, which is served by the register file's write-through.
  - fwd_a_e_o and fwd_b_e_o register this value when the D instruction advances. They register 0 when a bubble enters E.
- Output priority, highest first:
  - hold_i: stall_f/stall_d = 1, flush_d/flush_e = 0. The scoreboard, forward selects and counters are frozen.
  - redirect_e_i: flush_d = flush_e = 1, stall_f/stall_d = 0. Entry 0 (the redirecting instruction, including a JAL writing rd) still advances.
  - stall: stall_f = stall_d = flush_e = 1, flush_d = 0.
  - None of the above: all four outputs are 0.
- Stall and flush outputs are combinational from the current state and inputs.
- Reset: all entries are invalid; fwd_a_e_o, fwd_b_e_o and both counters are 0. With no inputs active, all stall and flush outputs are 0.

## Timing
- Stall decision: same cycle, no added latency.
- Forward selects: valid in the cycle the instruction occupies E, which is one edge after it leaves D.
- Load-use at default parameters: one stall cycle. The dependent instruction then sees forward select 2.
- ALU-use at the defaults: no stall, forward select 1.
- Redirect in the same cycle as a stall: redirect wins and no stall is recorded.
- hold_i in the same cycle as redirect: hold wins, and the redirect must be held by the source until hold_i drops.
- Reset asserted mid-operation: the scoreboard clears immediately. The first cycle after deassertion behaves as a cold start.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cnt_o increments on each cycle with stall & !hold_i & !redirect_e_i.
  - flush_cnt_o increments on each cycle with redirect_e_i & !hold_i.
  - Both counters saturate at 0xFFFF_FFFF.
- HAZARD_PERF_EN undefined: both counter ports are driven constant 0 and no counter flops are built.

## Test plan
- Writer to x5 in D, then a reader of x5 on the next cycle (defaults) -> no stall; fwd_a_e_o = 1 when the reader is in E.
- Load to x6, then a reader of x6 in the next D (defaults) -> one cycle of stall_f = stall_d = flush_e = 1; then fwd_b_e_o = 2.
- Writer to x0 followed by a reader of x0 -> no stall, fwd = 0; reader of x7 with its writer in W -> fwd = 0.
- Load-use stall coincident with redirect_e_i -> flush_d = flush_e = 1, stall_f = 0; stall_cnt_o unchanged.
- hold_i for 3 cycles during a load-use stall -> stall_f = 1 and flush_e = 0 throughout; after release, one stall cycle then fwd = 2, the same as without hold.
- HAZARD_PERF_EN defined, 2 stalls and 1 redirect -> stall_cnt_o = 2, flush_cnt_o = 1; asserting rst mid-run clears both to 0 immediately.
